spi_slave_gen: RTL and testbench

- Parametrised SPI slave: frames of a 2-bit command plus a DW-bit payload, shifted MSB-first on MOSI. Each completed frame is presented as a parallel word with a one-cycle valid pulse.
- On a read-data command, waits for the memory's tx_valid, then serialises DW bits on MISO.
- Sits between the external SPI master and the single-port RAM controller. clk is the SPI serial clock.
- Adds over the previous generation: width parameter, bit-exact frame counting, a synchronous read-address flag, frame-abort detection and selectable MISO bit order.

---
 rtl/spi_slave_gen_pkg.sv | 27 ++
 rtl/spi_slave_gen_if.sv | 28 ++
 rtl/spi_piso_shift.sv | 63 ++++++
 rtl/spi_slave_gen.sv | 149 ++++++++++++++
 tb/tb_spi_slave_gen.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_slave_gen_pkg.sv
// spi_slave_gen_pkg: shared types and constants for the SPI slave.
//   state_e    - main frame FSM states
//   tx_phase_e - MISO transmit sub-phase, meaningful only in READ_DATA
//   CMD_*      - 2-bit command codes carried in the frame header
package spi_slave_gen_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_e;

    typedef enum logic [1:0] {
        TX_NONE,  // no transmission pending
        TX_WAIT,  // waiting for tx_valid from memory
        TX_SEND,  // serialising tx_data on MISO
        TX_DONE   // word sent, MISO parked at 0 until SS_n rises
    } tx_phase_e;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_slave_gen_if.sv
// spi_slave_gen_if: SPI pins plus the parallel memory-side bus.
//   SS_n, MOSI, MISO      - serial SPI lines
//   tx_data, tx_valid     - read data offered by the memory controller
//   rx_data, rx_valid     - {cmd, payload} of each completed frame
//   frame_err, busy       - abort pulse and non-idle status
interface spi_slave_gen_if #(
    parameter int DW = 8
);
    logic          SS_n;
    logic          MOSI;
    logic          MISO;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic [DW+1:0] rx_data;
    logic          rx_valid;
    logic          frame_err;
    logic          busy;

    modport slave (
        input  SS_n, MOSI, tx_data, tx_valid,
        output MISO, rx_data, rx_valid, frame_err, busy
    );

    modport master (
        output SS_n, MOSI, tx_data, tx_valid,
        input  MISO, rx_data, rx_valid, frame_err, busy
    );
endinterface

// File: rtl/spi_piso_shift.sv
// spi_piso_shift: parallel-in serial-out register driving MISO.
//   clk, rst_n - clock, synchronous active-low reset
//   load       - capture din; its first bit appears on dout next cycle
//   din        - parallel word
//   shift      - hold high to keep transmitting; dropping it parks dout at 0
//   dout       - registered serial output
//   done       - high while the last bit of the word is on dout
module spi_piso_shift #(
    parameter int W         = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         shift,
    output logic         dout,
    output logic         done
);
    localparam int RW = $clog2(W);

    logic [W-1:0]  sr;
    logic [RW-1:0] rem;     // bits still to present after the current one
    logic          active;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr     <= '0;
            rem    <= '0;
            active <= 1'b0;
            dout   <= 1'b0;
        end else if (load) begin
            if (MSB_FIRST) begin
                dout <= din[W-1];
                sr   <= {din[W-2:0], 1'b0};
            end else begin
                dout <= din[0];
                sr   <= {1'b0, din[W-1:1]};
            end
            rem    <= RW'(W - 1);
            active <= 1'b1;
        end else if (shift && active && rem != '0) begin
            if (MSB_FIRST) begin
                dout <= sr[W-1];
                sr   <= {sr[W-2:0], 1'b0};
            end else begin
                dout <= sr[0];
                sr   <= {1'b0, sr[W-1:1]};
            end
            rem <= rem - RW'(1);
        end else begin
            // Word finished or transmission abandoned: MISO returns to 0.
            dout   <= 1'b0;
            rem    <= '0;
            active <= 1'b0;
        end
    end

    assign done = active && (rem == '0);

endmodule

// File: rtl/spi_slave_gen.sv
// spi_slave_gen: SPI slave framing {cmd[1:0], payload[DW-1:0]} MSB-first.
//   clk, rst_n - SPI clock (posedge logic), synchronous active-low reset
//   bus        - spi_slave_gen_if slave modport: SPI pins, tx_data/tx_valid
//                from memory, rx_data/rx_valid/frame_err/busy outputs
// A read-data frame (cmd 11) received after a read-address frame waits for
// tx_valid and then returns DW bits on MISO in TX_MSB_FIRST order.
module spi_slave_gen
    import spi_slave_gen_pkg::*;
#(
    parameter int DW           = 8,
    parameter bit TX_MSB_FIRST = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    spi_slave_gen_if.slave bus
);
    localparam int FRAME_LEN = DW + 2;
    localparam int CW        = $clog2(FRAME_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_LEN);

    state_e        state, state_nx;
    tx_phase_e     tx_phase, tx_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          has_read_addr, hra_nx;
    logic [DW+1:0] sr, frame, rx_data_q;
    logic          rx_valid_q, rx_valid_nx;
    logic          frame_err_q, frame_err_nx;
    logic [1:0]    frame_cmd;
    logic          sampling, complete, tx_active;
    logic          piso_load, piso_shift, piso_done, miso;

    // Frame as it stands once this cycle's MOSI bit is included.
    assign frame     = {sr[DW:0], bus.MOSI};
    assign frame_cmd = frame[DW+1:DW];
    // Bits are taken from CHK_CMD onward until the counter saturates.
    assign sampling  = (state != IDLE) && (cnt != CNT_FULL);
    assign complete  = sampling && (cnt == CNT_LAST);
    assign tx_active = (tx_phase == TX_WAIT) || (tx_phase == TX_SEND);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            tx_phase      <= TX_NONE;
            cnt           <= '0;
            has_read_addr <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state         <= state_nx;
            tx_phase      <= tx_nx;
            cnt           <= cnt_nx;
            has_read_addr <= hra_nx;
            rx_valid_q    <= rx_valid_nx;
            frame_err_q   <= frame_err_nx;
            if (complete) rx_data_q <= frame;
        end
    end

    // NOTE: the shift register is left out of reset; the bit counter makes
    // it fully overwritten before any of its contents are published.
    always_ff @(posedge clk) begin
        if (sampling) sr <= frame;
    end

    // NOTE: every signal gets its default before the case so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nx     = state;
        tx_nx        = tx_phase;
        cnt_nx       = cnt;
        hra_nx       = has_read_addr;
        rx_valid_nx  = 1'b0;
        frame_err_nx = 1'b0;
        piso_load    = 1'b0;
        piso_shift   = 1'b0;

        if (sampling) cnt_nx = cnt + CW'(1);

        case (state)
            IDLE: begin
                cnt_nx = '0;
                tx_nx  = TX_NONE;
                if (!bus.SS_n) state_nx = CHK_CMD;
            end
            CHK_CMD: begin
                if (!bus.MOSI)          state_nx = WRITE;
                else if (has_read_addr) state_nx = READ_DATA;
                else                    state_nx = READ_ADD;
            end
            READ_DATA: begin
                case (tx_phase)
                    TX_WAIT: begin
                        if (bus.tx_valid && !bus.SS_n) begin
                            piso_load = 1'b1;
                            tx_nx     = TX_SEND;
                        end
                    end
                    TX_SEND: begin
                        piso_shift = !bus.SS_n;
                        if (!bus.SS_n && piso_done) begin
                            tx_nx  = TX_DONE;
                            hra_nx = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase

        if (complete) begin
            rx_valid_nx = 1'b1;
            if (frame_cmd == CMD_RD_ADDR) hra_nx = 1'b1;
            if (state == READ_DATA && frame_cmd == CMD_RD_DATA && !bus.SS_n)
                tx_nx = TX_WAIT;
        end

        // Deselect wins over everything; a frame finishing on this very
        // cycle is still reported as good.
        if (state != IDLE && bus.SS_n) begin
            state_nx     = IDLE;
            cnt_nx       = '0;
            tx_nx        = TX_NONE;
            frame_err_nx = !complete && ((cnt != CNT_FULL) || tx_active);
        end
    end

    spi_piso_shift #(
        .W         (DW),
        .MSB_FIRST (TX_MSB_FIRST)
    ) u_piso (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (piso_load),
        .din   (bus.tx_data),
        .shift (piso_shift),
        .dout  (miso),
        .done  (piso_done)
    );

    assign bus.MISO      = miso;
    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_spi_slave_gen.sv
// tb_spi_slave_gen: drives one stimulus stream into an MSB-first and an
// LSB-first instance; received frames are checked against a queue of
// expected words filled as each frame is sent.
module tb_spi_slave_gen;
    import spi_slave_gen_pkg::*;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ss_n = 1'b1;
    logic          mosi = 1'b0;
    logic          tx_valid = 1'b0;
    logic [DW-1:0] tx_data = '0;

    int checks = 0;
    int failures = 0;
    int rxv_count = 0;
    int ferr_count = 0;
    logic [DW+1:0] rx_q[$];
    logic [DW+1:0] mon_exp;

    always #5 clk = ~clk;

    spi_slave_gen_if #(.DW(DW)) bus_m ();
    spi_slave_gen_if #(.DW(DW)) bus_l ();

    assign bus_m.SS_n = ss_n;
    assign bus_m.MOSI = mosi;
    assign bus_m.tx_valid = tx_valid;
    assign bus_m.tx_data = tx_data;
    assign bus_l.SS_n = ss_n;
    assign bus_l.MOSI = mosi;
    assign bus_l.tx_valid = tx_valid;
    assign bus_l.tx_data = tx_data;

    spi_slave_gen #(.DW(DW), .TX_MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst_n(rst_n), .bus(bus_m));
    spi_slave_gen #(.DW(DW), .TX_MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst_n(rst_n), .bus(bus_l));

    // Scoreboard side: each rx_valid pops one expected frame.
    always @(negedge clk) begin
        if (bus_m.rx_valid === 1'b1) begin
            rxv_count++;
            checks++;
            if (rx_q.size() == 0) begin
                failures++;
                $display("FAIL rx_unexpected: rx_data=%h with no frame outstanding", bus_m.rx_data);
            end else begin
                mon_exp = rx_q.pop_front();
                if (bus_l.rx_valid !== 1'b1 || bus_m.rx_data !== mon_exp || bus_l.rx_data !== mon_exp) begin
                    failures++;
                    $display("FAIL rx_data: got msb=%h lsb=%h (lsb valid %b), expected %h",
                             bus_m.rx_data, bus_l.rx_data, bus_l.rx_valid, mon_exp);
                end
            end
        end
        if (bus_m.frame_err === 1'b1) ferr_count++;
    end

    task automatic send_frame(input logic [1:0] cmd, input logic [DW-1:0] payload);
        logic [DW+1:0] w;
        w = {cmd, payload};
        rx_q.push_back(w);
        @(negedge clk); ss_n = 1'b0; mosi = 1'b0;
        for (int i = DW + 1; i >= 0; i--) begin
            @(negedge clk); mosi = w[i];
        end
    endtask

    task automatic frame_end;
        @(negedge clk); ss_n = 1'b1; mosi = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain;
        for (int i = 0; i < 8 && rx_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (rx_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d frames still pending, expected 0", rx_q.size());
        end
    endtask

    task automatic test_reset;
        ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus_m.MISO, bus_l.MISO, bus_m.rx_valid, bus_m.frame_err, bus_m.busy} !== 5'b0
            || bus_m.rx_data !== '0) begin
            failures++;
            $display("FAIL reset_outputs: miso=%b/%b rxv=%b ferr=%b busy=%b rx=%h, expected all 0",
                     bus_m.MISO, bus_l.MISO, bus_m.rx_valid, bus_m.frame_err, bus_m.busy, bus_m.rx_data);
        end
        checks++;
        if (dut_m.has_read_addr !== 1'b0) begin
            failures++;
            $display("FAIL reset_hra: got %b expected 0", dut_m.has_read_addr);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write;
        int rv0, fe0;
        rv0 = rxv_count; fe0 = ferr_count;
        send_frame(CMD_WR_ADDR, 8'hA5);
        frame_end();
        drain();
        checks++;
        if (rxv_count - rv0 != 1 || ferr_count != fe0 || dut_m.has_read_addr !== 1'b0) begin
            failures++;
            $display("FAIL write_pulses: rx_valid=%0d frame_err=%0d hra=%b, expected 1 0 0",
                     rxv_count - rv0, ferr_count - fe0, dut_m.has_read_addr);
        end
    endtask

    task automatic test_read_tx(input logic [DW-1:0] d, input int wait_cycles);
        int rv0, fe0;
        rv0 = rxv_count; fe0 = ferr_count;
        send_frame(CMD_RD_ADDR, 8'h0F);
        frame_end();
        checks++;
        if (dut_m.has_read_addr !== 1'b1 || dut_l.has_read_addr !== 1'b1) begin
            failures++;
            $display("FAIL read_addr_flag: got %b/%b expected 1", dut_m.has_read_addr, dut_l.has_read_addr);
        end
        send_frame(CMD_RD_DATA, 8'h00);
        for (int i = 0; i < wait_cycles; i++) begin
            @(negedge clk);
            checks++;
            if (bus_m.MISO !== 1'b0 || bus_l.MISO !== 1'b0) begin
                failures++;
                $display("FAIL tx_wait_miso[%0d]: got %b/%b expected 0", i, bus_m.MISO, bus_l.MISO);
            end
        end
        @(negedge clk); tx_valid = 1'b1; tx_data = d;
        for (int i = 0; i < DW; i++) begin
            @(negedge clk); tx_valid = 1'b0;
            checks++;
            if (bus_m.MISO !== d[DW-1-i] || bus_l.MISO !== d[i]) begin
                failures++;
                $display("FAIL tx_bit[%0d] data=%h: got msb=%b lsb=%b expected msb=%b lsb=%b",
                         i, d, bus_m.MISO, bus_l.MISO, d[DW-1-i], d[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (bus_m.MISO !== 1'b0 || bus_l.MISO !== 1'b0 || dut_m.has_read_addr !== 1'b0) begin
            failures++;
            $display("FAIL tx_end: miso=%b/%b hra=%b expected 0 0 0", bus_m.MISO, bus_l.MISO, dut_m.has_read_addr);
        end
        // A late tx_valid must not restart transmission.
        tx_valid = 1'b1; tx_data = 8'hFF;
        @(negedge clk); tx_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_m.MISO !== 1'b0 || bus_l.MISO !== 1'b0) begin
            failures++;
            $display("FAIL tx_late_valid: miso=%b/%b expected 0", bus_m.MISO, bus_l.MISO);
        end
        frame_end();
        drain();
        checks++;
        if (rxv_count - rv0 != 2 || ferr_count != fe0) begin
            failures++;
            $display("FAIL read_pulses: rx_valid=%0d frame_err=%0d expected 2 0", rxv_count - rv0, ferr_count - fe0);
        end
    endtask

    task automatic test_abort;
        int rv0, fe0;
        logic [4:0] bits;
        send_frame(CMD_RD_ADDR, 8'h3C);
        frame_end();
        drain();
        rv0 = rxv_count; fe0 = ferr_count;
        bits = 5'b11001;
        @(negedge clk); ss_n = 1'b0;
        for (int i = 4; i >= 0; i--) begin
            @(negedge clk); mosi = bits[i];
        end
        @(negedge clk); ss_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus_m.frame_err !== 1'b1 || bus_l.frame_err !== 1'b1 || bus_m.busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_pulse: frame_err=%b/%b busy=%b expected 1 1 0", bus_m.frame_err, bus_l.frame_err, bus_m.busy);
        end
        @(negedge clk);
        checks++;
        if (bus_m.frame_err !== 1'b0 || ferr_count - fe0 != 1 || rxv_count != rv0 || dut_m.has_read_addr !== 1'b1) begin
            failures++;
            $display("FAIL abort_after: frame_err=%b errs=%0d rx_valid=%0d hra=%b expected 0 1 0 1",
                     bus_m.frame_err, ferr_count - fe0, rxv_count - rv0, dut_m.has_read_addr);
        end
    endtask

    task automatic test_tx_abort;
        int rv0, fe0;
        rv0 = rxv_count; fe0 = ferr_count;
        send_frame(CMD_RD_DATA, 8'h55);
        @(negedge clk); tx_valid = 1'b1; tx_data = 8'hF0;
        @(negedge clk); tx_valid = 1'b0;
        checks++;
        if (bus_m.MISO !== 1'b1 || bus_l.MISO !== 1'b0) begin
            failures++;
            $display("FAIL tx_abort_first_bit: got %b/%b expected 1/0", bus_m.MISO, bus_l.MISO);
        end
        @(negedge clk); ss_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus_m.frame_err !== 1'b1 || bus_m.MISO !== 1'b0 || bus_l.MISO !== 1'b0
            || bus_m.busy !== 1'b0 || dut_m.has_read_addr !== 1'b1) begin
            failures++;
            $display("FAIL tx_truncate: ferr=%b miso=%b/%b busy=%b hra=%b expected 1 0 0 0 1",
                     bus_m.frame_err, bus_m.MISO, bus_l.MISO, bus_m.busy, dut_m.has_read_addr);
        end
        @(negedge clk);
        drain();
        checks++;
        if (rxv_count - rv0 != 1 || ferr_count - fe0 != 1) begin
            failures++;
            $display("FAIL tx_abort_pulses: rx_valid=%0d frame_err=%0d expected 1 1", rxv_count - rv0, ferr_count - fe0);
        end
    endtask

    task automatic test_rst_mid_tx;
        int rv0, fe0;
        send_frame(CMD_RD_DATA, 8'hAA);
        @(negedge clk); tx_valid = 1'b1; tx_data = 8'hFF;
        @(negedge clk); tx_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_m.MISO !== 1'b1 || bus_l.MISO !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre_tx: miso=%b/%b expected 1", bus_m.MISO, bus_l.MISO);
        end
        rv0 = rxv_count; fe0 = ferr_count;
        rst_n = 1'b0; ss_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus_m.MISO, bus_l.MISO, bus_m.rx_valid, bus_m.frame_err, bus_m.busy, dut_m.has_read_addr} !== 6'b0
            || bus_m.rx_data !== '0) begin
            failures++;
            $display("FAIL rst_mid_tx: miso=%b/%b rxv=%b ferr=%b busy=%b hra=%b rx=%h expected all 0",
                     bus_m.MISO, bus_l.MISO, bus_m.rx_valid, bus_m.frame_err, bus_m.busy,
                     dut_m.has_read_addr, bus_m.rx_data);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (rxv_count != rv0 || ferr_count != fe0 || bus_m.busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_no_pulse: rx_valid=%0d frame_err=%0d busy=%b expected 0 0 0",
                     rxv_count - rv0, ferr_count - fe0, bus_m.busy);
        end
    endtask

    task automatic test_extra_bits;
        int rv0, fe0;
        logic [DW+1:0] w;
        rv0 = rxv_count; fe0 = ferr_count;
        w = {CMD_WR_DATA, 8'h5A};
        send_frame(CMD_WR_DATA, 8'h5A);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); mosi = 1'b1;
        end
        frame_end();
        drain();
        checks++;
        if (rxv_count - rv0 != 1 || ferr_count != fe0 || bus_m.rx_data !== w) begin
            failures++;
            $display("FAIL extra_bits: rx_valid=%0d frame_err=%0d rx=%h expected 1 0 %h",
                     rxv_count - rv0, ferr_count - fe0, bus_m.rx_data, w);
        end
    endtask

    task automatic test_complete_with_ss;
        int fe0;
        logic [DW+1:0] w;
        fe0 = ferr_count;
        w = {CMD_WR_ADDR, 8'h81};
        rx_q.push_back(w);
        @(negedge clk); ss_n = 1'b0;
        for (int i = DW + 1; i >= 1; i--) begin
            @(negedge clk); mosi = w[i];
        end
        @(negedge clk); mosi = w[0]; ss_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus_m.rx_valid !== 1'b1 || bus_m.frame_err !== 1'b0 || bus_m.busy !== 1'b0) begin
            failures++;
            $display("FAIL complete_with_ss: rxv=%b ferr=%b busy=%b expected 1 0 0",
                     bus_m.rx_valid, bus_m.frame_err, bus_m.busy);
        end
        @(negedge clk);
        drain();
        checks++;
        if (ferr_count != fe0) begin
            failures++;
            $display("FAIL complete_with_ss_err: frame_err=%0d expected 0", ferr_count - fe0);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_tx(8'hC3, 3);
        test_abort();
        test_tx_abort();
        test_rst_mid_tx();
        test_read_tx(8'h01, 0);
        test_extra_bits();
        test_complete_with_ss();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
